// File: rtl/aes_sbox_pkg.sv
// aes_sbox_pkg: GF(2^8) constants, FSM states and affine helpers shared by the S-box paths.
package aes_sbox_pkg;
    localparam logic [7:0] GF_POLY      = 8'h1B;
    localparam logic [7:0] INV_AFFINE_C = 8'h05;
    localparam logic [7:0] AFFINE_C     = 8'h63;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MUL, S_DONE} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ INV_AFFINE_C;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ AFFINE_C;
    endfunction
endpackage

// File: rtl/gf256_mul_serial.sv
// gf256_mul_serial: Horner-form GF(2^8) multiplier, BITS_PER_CYCLE multiplier bits per clock.
// The first chunk is consumed on the go edge so rdy lands exactly MUL_CYC cycles after go.
module gf256_mul_serial
    import aes_sbox_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    output logic [7:0] prod,
    output logic       rdy
);
    localparam int MUL_CYC = 8 / BITS_PER_CYCLE;

    logic [7:0] a_q, b_q, src_a, src_b, acc_nx;
    logic [3:0] cnt;

    always_comb begin
        src_a  = go ? op_a : a_q;
        src_b  = go ? op_b : b_q;
        acc_nx = go ? 8'h00 : prod;
        for (int i = 0; i < BITS_PER_CYCLE; i++)
            acc_nx = xtime(acc_nx) ^ (src_b[7-i] ? src_a : 8'h00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= 8'h00;
            b_q  <= 8'h00;
            prod <= 8'h00;
            cnt  <= 4'd0;
            rdy  <= 1'b0;
        end else if (go) begin
            a_q  <= op_a;
            b_q  <= op_b << BITS_PER_CYCLE;
            prod <= acc_nx;
            cnt  <= 4'(MUL_CYC - 1);
            rdy  <= (MUL_CYC == 1);
        end else if (cnt != 4'd0) begin
            b_q  <= b_q << BITS_PER_CYCLE;
            prod <= acc_nx;
            cnt  <= cnt - 4'd1;
            rdy  <= (cnt == 4'd1);
        end else begin
            rdy  <= 1'b0;
        end
    end
endmodule

// File: rtl/aes_inv_sbox_seq.sv
// aes_inv_sbox_seq: sequential AES inverse S-box; InvAffine then a^254 via 13 serial multiplies.
module aes_inv_sbox_seq
    import aes_sbox_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic       CLOCK_50,
    input  logic       KEY,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] data_out
);
    state_t     state, state_nx;
    logic [7:0] a, r, prod, op_a, op_b;
    logic [2:0] step;
    logic       phase, rdy, go, last;

    gf256_mul_serial #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_mul (
        .clk(CLOCK_50), .rst_n(KEY), .go(go), .op_a(op_a), .op_b(op_b), .prod(prod), .rdy(rdy)
    );

    // Next multiply is launched on the rdy cycle itself, so operands forward prod, not r.
    always_comb begin
        last     = step == 3'd6;
        go       = (state == S_LOAD) || (state == S_MUL && rdy && !last);
        op_a     = state == S_LOAD ? a : prod;
        op_b     = (state == S_MUL && !phase) ? a : op_a;
        state_nx = state == S_IDLE ? (start ? S_LOAD : S_IDLE) :
                   state == S_LOAD ? S_MUL :
                   state == S_MUL  ? ((rdy && last) ? S_DONE : S_MUL) : S_IDLE;
    end

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            a        <= 8'h00;
            r        <= 8'h00;
            step     <= 3'd0;
            phase    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            data_out <= 8'h00;
        end else begin
            busy <= (state_nx != S_IDLE) || (state == S_DONE);
            done <= state == S_DONE;
            if (state == S_DONE) data_out <= r;
            if (state == S_IDLE && start) a <= inv_affine(data_in);
            if (state == S_LOAD) begin
                r     <= a;
                step  <= 3'd0;
                phase <= 1'b0;
            end else if (state == S_MUL && rdy) begin
                r     <= prod;
                phase <= ~phase;
                if (phase) step <= step + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_aes_inv_sbox_seq.sv
// tb_aes_inv_sbox_seq: four DUTs (1,2,4,8 bits/cycle) on shared stimulus, checked against
// an S-box table built from field inversion by search and the forward affine map.
module tb_aes_inv_sbox_seq;
    logic       CLOCK_50 = 1'b0;
    logic       KEY = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       busy_v [4];
    logic       done_v [4];
    logic [7:0] dout_v [4];
    logic [7:0] fwd [256];
    logic [7:0] invt [256];
    int         lat_v [4];
    logic [7:0] res_v [4];
    logic       b_acc;
    int         checks = 0;
    int         errors = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : gen_dut
            aes_inv_sbox_seq #(.BITS_PER_CYCLE(1 << g)) dut (
                .CLOCK_50(CLOCK_50), .KEY(KEY), .start(start), .data_in(data_in),
                .busy(busy_v[g]), .done(done_v[g]), .data_out(dout_v[g])
            );
        end
    endgenerate

    function automatic int gmul(input int x, input int y);
        int p = 0;
        int aa = x;
        int bb = y;
        for (int i = 0; i < 8; i++) begin
            if ((bb & 1) != 0) p = p ^ aa;
            aa = aa << 1;
            if ((aa & 'h100) != 0) aa = aa ^ 'h11B;
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic int rotl8(input int v, input int n);
        return ((v << n) | (v >> (8 - n))) & 255;
    endfunction

    function automatic int exp_lat(input int j);
        return 2 + 13 * (8 >> j);
    endfunction

    task automatic build_model();
        for (int x = 0; x < 256; x++) begin
            int iv = 0;
            int s;
            for (int y = 1; y < 256; y++) if (x != 0 && gmul(x, y) == 1) iv = y;
            s = iv ^ rotl8(iv, 1) ^ rotl8(iv, 2) ^ rotl8(iv, 3) ^ rotl8(iv, 4) ^ 'h63;
            fwd[x] = 8'(s);
            invt[s] = 8'(x);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic run_one(input logic [7:0] x);
        start = 1'b1;
        data_in = x;
        tick();
        start = 1'b0;
        data_in = 8'($urandom);
        b_acc = busy_v[0];
        for (int j = 0; j < 4; j++) begin
            lat_v[j] = -1;
            res_v[j] = 8'h00;
        end
        for (int n = 1; n <= 130; n++) begin
            tick();
            for (int j = 0; j < 4; j++)
                if (done_v[j] === 1'b1 && lat_v[j] < 0) begin
                    lat_v[j] = n;
                    res_v[j] = dout_v[j];
                end
        end
    endtask

    task automatic test_reset();
        #5;
        for (int j = 0; j < 4; j++) begin
            checks++;
            if ({busy_v[j], done_v[j], dout_v[j]} !== 10'h000) begin
                errors++;
                $display("FAIL reset dut%0d busy=%b done=%b data_out=%h want 0 0 00", j, busy_v[j], done_v[j], dout_v[j]);
            end
        end
        tick();
        tick();
        KEY = 1'b1;
        tick();
    endtask

    task automatic test_zero();
        run_one(8'h63);
        checks++;
        if (b_acc !== 1'b1) begin
            errors++;
            $display("FAIL zero_busy got %b want 1", b_acc);
        end
        checks++;
        if (lat_v[0] != 106) begin
            errors++;
            $display("FAIL zero_latency got %0d want 106", lat_v[0]);
        end
        checks++;
        if (res_v[0] !== 8'h00) begin
            errors++;
            $display("FAIL zero_data got %h want 00", res_v[0]);
        end
    endtask

    task automatic test_sequence();
        logic [7:0] ins [4] = '{8'h7C, 8'h00, 8'hED, 8'h16};
        logic [7:0] outs [4] = '{8'h01, 8'h52, 8'h53, 8'hFF};
        for (int i = 0; i < 4; i++) begin
            run_one(ins[i]);
            checks++;
            if (res_v[0] !== outs[i] || dout_v[0] !== outs[i]) begin
                errors++;
                $display("FAIL sequence in=%h got %h held %h want %h", ins[i], res_v[0], dout_v[0], outs[i]);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [7:0] perm [256];
        for (int i = 0; i < 256; i++) perm[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            int k = int'($urandom_range(0, i));
            logic [7:0] t = perm[i];
            perm[i] = perm[k];
            perm[k] = t;
        end
        for (int i = 0; i < 256; i++) begin
            run_one(perm[i]);
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (lat_v[j] != exp_lat(j)) begin
                    errors++;
                    $display("FAIL exh_latency dut%0d in=%h got %0d want %0d", j, perm[i], lat_v[j], exp_lat(j));
                end
                checks++;
                if (res_v[j] !== invt[perm[i]] || fwd[res_v[j]] !== perm[i]) begin
                    errors++;
                    $display("FAIL exh_data dut%0d in=%h got %h want %h", j, perm[i], res_v[j], invt[perm[i]]);
                end
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [7:0] x;
        int cnt = 0;
        int first = -1;
        do x = 8'($urandom); while (x == 8'h63);
        start = 1'b1;
        data_in = x;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 4; n++) tick();
        start = 1'b1;
        data_in = 8'h00;
        tick();
        start = 1'b0;
        for (int n = 6; n <= 220; n++) begin
            tick();
            if (done_v[0] === 1'b1) begin
                cnt++;
                if (first < 0) first = n;
            end
        end
        checks++;
        if (cnt != 1 || first != 106) begin
            errors++;
            $display("FAIL busy_ignore dones=%0d first=%0d want 1 at 106", cnt, first);
        end
        checks++;
        if (dout_v[0] !== invt[x]) begin
            errors++;
            $display("FAIL busy_ignore_data got %h want %h", dout_v[0], invt[x]);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] x = 8'($urandom);
        int cnt = 0;
        start = 1'b1;
        data_in = x;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 39; n++) tick();
        #9;
        KEY = 1'b0;
        #1;
        checks++;
        if (busy_v[0] !== 1'b0 || dout_v[0] !== 8'h00 || done_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid busy=%b done=%b data_out=%h want 0 0 00", busy_v[0], done_v[0], dout_v[0]);
        end
        for (int n = 0; n < 3; n++) tick();
        KEY = 1'b1;
        for (int n = 0; n < 200; n++) begin
            tick();
            for (int j = 0; j < 4; j++) if (done_v[j] === 1'b1) cnt++;
        end
        checks++;
        if (cnt != 0) begin
            errors++;
            $display("FAIL reset_mid_nodone got %0d dones want 0", cnt);
        end
        x = 8'($urandom);
        run_one(x);
        checks++;
        if (lat_v[0] != 106 || res_v[0] !== invt[x]) begin
            errors++;
            $display("FAIL reset_mid_restart lat=%0d data=%h want 106 %h", lat_v[0], res_v[0], invt[x]);
        end
    endtask

    task automatic test_back_to_back();
        int offs [$];
        logic [7:0] vals [$];
        start = 1'b1;
        data_in = 8'h7C;
        tick();
        for (int n = 1; n <= 330; n++) begin
            tick();
            if (done_v[0] === 1'b1) begin
                offs.push_back(n);
                vals.push_back(dout_v[0]);
            end
        end
        start = 1'b0;
        checks++;
        if (offs.size() != 3) begin
            errors++;
            $display("FAIL b2b_count got %0d want 3", offs.size());
        end
        for (int i = 0; i < offs.size() && i < 3; i++) begin
            checks++;
            if (offs[i] != 106 + 107 * i || vals[i] !== 8'h01) begin
                errors++;
                $display("FAIL b2b_done%0d at %0d data %h want %0d 01", i, offs[i], vals[i], 106 + 107 * i);
            end
        end
        for (int n = 0; n < 120; n++) tick();
    endtask

    initial begin
        build_model();
        test_reset();
        test_zero();
        test_sequence();
        test_exhaustive();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
